reg_file_sb: RTL and testbench

- Parametrised general-purpose register file for the datapath. It is the successor of the fixed 8x16, 2-read-port file.
- Provides NUM_RD combinational read ports, one synchronous write port, and write-to-read bypass.
- Includes a per-register busy scoreboard for the issue stage.
- Includes a sequenced bulk-clear engine that zeroes the file one entry per cycle without needing a reset.

---
 rtl/reg_file_sb.sv | 148 ++++++++++++++
 tb/tb_reg_file_sb.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with NUM_RD combinational read ports,
// one synchronous write port, write-to-read bypass, a per-register busy
// scoreboard and a sequenced bulk-clear engine (one entry zeroed per cycle).
//
// Optional build macro: REG_FILE_ZERO_REG_EN
//   When defined, register 0 is hardwired to zero: reads of address 0 return 0
//   (no bypass), writes to address 0 are discarded and busy[0] is always 0.
module reg_file_sb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(2**ADDR_W)-1:0]   busy,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Counter is one bit wider than the address so it can never wrap mid-sweep.
  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic              wr_ok;
  logic              rsv_ok;
  logic [ADDR_W-1:0] clr_idx;

  assign clr_idx = cnt_q[ADDR_W-1:0];

  // Qualify write and reserve strobes: only honoured while idle.
  always_comb begin
    wr_ok  = wr_en && (state_q == StIdle);
    rsv_ok = rsv_en && (state_q == StIdle);
`ifdef REG_FILE_ZERO_REG_EN
    wr_ok  = wr_ok && (wr_addr != '0);
    rsv_ok = rsv_ok && (rsv_addr != '0);
`endif
  end

  // Clear-sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage and scoreboard next-state: write, reserve, then sweep.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Applied after the write so a same-address reserve wins.
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (state_q == StClear) begin
      regs_d[clr_idx] = '0;
      busy_d[clr_idx] = 1'b0;
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read ports with same-cycle write bypass while idle.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
      if (wr_ok && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
      end
`ifdef REG_FILE_ZERO_REG_EN
      if (rd_addr[k*ADDR_W +: ADDR_W] == '0) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end
`endif
    end
  end

  // Status outputs decoded from the sequencer state.
  always_comb begin
    busy     = busy_q;
    clr_busy = (state_q != StIdle);
    clr_done = (state_q == StDone);
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (DATA_W=16, ADDR_W=3, NUM_RD=2).
// Expected values are queued when stimulus is applied and popped at sampling.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic [7:0]  busy;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  reg_file_sb #(
    .DATA_W(16),
    .ADDR_W(3),
    .NUM_RD(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle_inputs();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    clr_req  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    set_rd(3, 3);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (busy !== exp_v[7:0]) begin
      errors++; $display("FAIL reset_busy got %h want %h", busy, exp_v[7:0]);
    end
    exp_v = exp_q.pop_front(); checks++;
    if ({clr_busy, clr_done} !== exp_v[1:0]) begin
      errors++; $display("FAIL reset_clr got %b want %b", {clr_busy, clr_done}, exp_v[1:0]);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL reset_rd got %h want %h", rd_data, exp_v);
    end
    // Write r3, read it from storage on the following cycle.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    set_rd(0, 0);
    exp_q.push_back(32'h1234_1234);
    @(negedge clk);
    wr_en = 1'b0;
    set_rd(3, 3);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL write_r3 got %h want %h", rd_data, exp_v);
    end
    // Reserve r5, then pulse rst between edges.
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 3'd5;
    exp_q.push_back(32'h20);
    @(negedge clk);
    rsv_en = 1'b0;
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (busy !== exp_v[7:0]) begin
      errors++; $display("FAIL rsv_r5 got %h want %h", busy, exp_v[7:0]);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1 rst = 1'b1;
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL midrst_rd got %h want %h", rd_data, exp_v);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (busy !== exp_v[7:0]) begin
      errors++; $display("FAIL midrst_busy got %h want %h", busy, exp_v[7:0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0042;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
    set_rd(5, 4);
    exp_q.push_back(32'h0042_BEEF);
    exp_q.push_back(32'h0042_BEEF);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL bypass got %h want %h", rd_data, exp_v);
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL bypass_stored got %h want %h", rd_data, exp_v);
    end
  endtask

  task automatic test_scoreboard();
    // Each step: drive, then compare busy at the following negedge.
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      idle_inputs();
      case (s)
        0: begin rsv_en = 1; rsv_addr = 3'd2; exp_q.push_back(32'h04); end
        1: begin wr_en = 1; wr_addr = 3'd2; wr_data = 16'h2; exp_q.push_back(32'h00); end
        2: begin
          rsv_en = 1; rsv_addr = 3'd6; wr_en = 1; wr_addr = 3'd6; wr_data = 16'h6;
          exp_q.push_back(32'h40);
        end
        3: begin wr_en = 1; wr_addr = 3'd1; wr_data = 16'h1; exp_q.push_back(32'h40); end
        4: begin rsv_en = 1; rsv_addr = 3'd6; exp_q.push_back(32'h40); end
        default: begin
          rsv_en = 1; rsv_addr = 3'd3; wr_en = 1; wr_addr = 3'd6; wr_data = 16'h6;
          exp_q.push_back(32'h08);
        end
      endcase
      @(negedge clk);
      idle_inputs();
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (busy !== exp_v[7:0]) begin
        errors++; $display("FAIL sb_step%0d got %h want %h", s, busy, exp_v[7:0]);
      end
    end
    // Release r3 so later tests start from an empty scoreboard.
    @(negedge clk);
    wr_en = 1; wr_addr = 3'd3; wr_data = 16'h3;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h1111 * (i + 1));
    end
    @(negedge clk);
    idle_inputs();
    rsv_en = 1'b1; rsv_addr = 3'd7;
    @(negedge clk);
    idle_inputs();
    set_rd(6, 7);
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h8888_7777);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (busy !== exp_v[7:0]) begin
      errors++; $display("FAIL clr_pre_busy got %h want %h", busy, exp_v[7:0]);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL clr_pre_rd got %h want %h", rd_data, exp_v);
    end
    @(negedge clk);
    clr_req = 1'b1;
    exp_q.push_back(32'h8888_8888);
    exp_q.push_back(32'h8888_0000);
    exp_q.push_back(32'h80);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      idle_inputs();
      if (cyc == 2) begin
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 3'd3;
        set_rd(7, 7);
      end else if (cyc == 3) begin
        set_rd(1, 7);
      end else if (cyc == 5) begin
        clr_req = 1'b1;
      end
      #1;
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_cyc = cyc; end
      if (cyc == 2) begin
        exp_v = exp_q.pop_front(); checks++;
        if (rd_data !== exp_v) begin
          errors++; $display("FAIL clr_nobypass got %h want %h", rd_data, exp_v);
        end
      end else if (cyc == 3) begin
        exp_v = exp_q.pop_front(); checks++;
        if (rd_data !== exp_v) begin
          errors++; $display("FAIL clr_partial got %h want %h", rd_data, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (busy !== exp_v[7:0]) begin
          errors++; $display("FAIL clr_mid_busy got %h want %h", busy, exp_v[7:0]);
        end
      end
    end
    exp_q.push_back(32'd9);
    exp_q.push_back(32'd9);
    exp_q.push_back(32'd1);
    exp_v = exp_q.pop_front(); checks++;
    if (busy_cnt !== int'(exp_v)) begin
      errors++; $display("FAIL clr_busy_cycles got %0d want %0d", busy_cnt, exp_v);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (done_cyc !== int'(exp_v)) begin
      errors++; $display("FAIL clr_done_cycle got %0d want %0d", done_cyc, exp_v);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (done_cnt !== int'(exp_v)) begin
      errors++; $display("FAIL clr_done_width got %0d want %0d", done_cnt, exp_v);
    end
    for (int a = 0; a < 8; a += 2) begin
      set_rd(3'(a), 3'(a + 1));
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data !== exp_v) begin
        errors++; $display("FAIL clr_final_r%0d got %h want %h", a, rd_data, exp_v);
      end
    end
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if (busy !== exp_v[7:0]) begin
      errors++; $display("FAIL clr_final_busy got %h want %h", busy, exp_v[7:0]);
    end
  endtask

  task automatic test_clear_reset();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
    exp_q.push_back(32'h6666_6666);
    @(negedge clk);
    idle_inputs();
    set_rd(6, 6);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL clrrst_pre got %h want %h", rd_data, exp_v);
    end
    @(negedge clk);
    clr_req = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      clr_req = 1'b0;
    end
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (clr_busy !== exp_v[0]) begin
      errors++; $display("FAIL clrrst_active got %b want %b", clr_busy, exp_v[0]);
    end
    #1 rst = 1'b1;
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if ({clr_busy, clr_done} !== exp_v[1:0]) begin
      errors++; $display("FAIL clrrst_abort got %b want %b", {clr_busy, clr_done}, exp_v[1:0]);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL clrrst_rd got %h want %h", rd_data, exp_v);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (busy !== exp_v[7:0]) begin
      errors++; $display("FAIL clrrst_busy got %h want %h", busy, exp_v[7:0]);
    end
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h2222_2222);
    @(negedge clk);
    idle_inputs();
    set_rd(2, 2);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (clr_busy !== exp_v[0]) begin
      errors++; $display("FAIL clrrst_idle got %b want %b", clr_busy, exp_v[0]);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL clrrst_write got %h want %h", rd_data, exp_v);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hAAAA;
    set_rd(0, 0);
    exp_q.push_back(ZeroReg ? 32'h0 : 32'hAAAA_AAAA);
    exp_q.push_back(ZeroReg ? 32'h0 : 32'hAAAA_AAAA);
    exp_q.push_back(ZeroReg ? 32'h0 : 32'h1);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL zr_same got %h want %h", rd_data, exp_v);
    end
    @(negedge clk);
    idle_inputs();
    rsv_en = 1'b1; rsv_addr = 3'd0;
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data !== exp_v) begin
      errors++; $display("FAIL zr_next got %h want %h", rd_data, exp_v);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (busy !== exp_v[7:0]) begin
      errors++; $display("FAIL zr_busy got %h want %h", busy, exp_v[7:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    rd_addr = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_clear_reset();
    test_zero_reg();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
